// File: rtl/shift_add_multiplier_ctrl.sv
// shift_add_multiplier_ctrl: multi-cycle unsigned shift-add multiplier (MUL unit).
// One shared WIDTH-bit ripple-carry adder (half/full adder cells) is sequenced
// by a start/busy/done FSM over WIDTH iterations; product held until next start.
// Optional feature macro: ZERO_SKIP_EN (zero operand finishes after one edge).

// Half adder cell: sum and carry of two bits.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

// Full adder cell: sum and carry of two bits plus carry-in.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module shift_add_multiplier_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [WIDTH-1:0] m_reg, m_next;
  logic [PW-1:0]    p_reg, p_next;
  logic [CW-1:0]    count, count_next;
  logic             busy_next, done_next;

  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_s;
  logic [WIDTH:1]   carry;
  logic             add_c;

  // Shared ripple-carry adder: upper half of P plus Mreg, carry-in 0 (bit 0 is a half adder).
  assign add_a = p_reg[PW-1:WIDTH];

  half_adder u_ha0 (
    .a (add_a[0]),
    .b (m_reg[0]),
    .s (add_s[0]),
    .c (carry[1])
  );

  genvar i;
  generate
    for (i = 1; i < WIDTH; i++) begin : g_fa
      full_adder u_fa (
        .a    (add_a[i]),
        .b    (m_reg[i]),
        .cin  (carry[i]),
        .s    (add_s[i]),
        .cout (carry[i+1])
      );
    end
  endgenerate

  assign add_c = carry[WIDTH];

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      m_reg <= '0;
      p_reg <= '0;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      m_reg <= m_next;
      p_reg <= p_next;
      count <= count_next;
      busy  <= busy_next;
      done  <= done_next;
    end
  end

  // Next-state, datapath update and output decode.
  always_comb begin
    state_next = state;
    m_next     = m_reg;
    p_next     = p_reg;
    count_next = count;

    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          m_next     = multiplicand;
          p_next     = {WIDTH'(0), multiplier};
          count_next = '0;
`ifdef ZERO_SKIP_EN
          // Zero operand: clear P and jump to the last iteration; P stays 0, adder unused.
          if ((multiplicand == '0) || (multiplier == '0)) begin
            p_next     = '0;
            count_next = CW'(WIDTH - 1);
          end
`endif
        end
      end
      RUN: begin
        // Carry-out lands in the top bit after the shift, so no product bit is lost.
        if (p_reg[0]) begin
          p_next = {add_c, add_s, p_reg[WIDTH-1:1]};
        end else begin
          p_next = {1'b0, p_reg[PW-1:1]};
        end
        count_next = count + CW'(1);
        if (count == CW'(WIDTH - 1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    busy_next = (state_next != IDLE);
    done_next = (state_next == DONE);
  end

  assign product = p_reg;

endmodule

// File: tb/tb_shift_add_multiplier_ctrl.sv
// Directed self-checking bench for shift_add_multiplier_ctrl (WIDTH=8).
module tb_shift_add_multiplier_ctrl;

  localparam int unsigned WIDTH = 8;
`ifdef ZERO_SKIP_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = 8;
`endif

  logic               clk;
  logic               reset;
  logic               start;
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  int n_checks;
  int n_fail;
  int cyc;

  shift_add_multiplier_ctrl #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Tick until done is seen, bounded; n = edges taken.
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
  endtask

  // Single-pulse operation: check latency, product, and return to idle.
  task automatic run_op(input string tag, input logic [7:0] m, input logic [7:0] q,
                        input logic [15:0] exp_p, input int exp_lat);
    int n;
    multiplicand = m;
    multiplier   = q;
    start        = 1'b1;
    tick();
    start = 1'b0;
    check_eq({tag, "_busy"}, 32'(busy), 32'd1);
    wait_done(n);
    check_eq({tag, "_lat"}, 32'(n), 32'(exp_lat));
    check_eq({tag, "_prod"}, 32'(product), 32'(exp_p));
    tick();
    check_eq({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
    check_eq({tag, "_hold"}, 32'(product), 32'(exp_p));
  endtask

  initial begin
    int n;
    int d1, d2;
    int seen;
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    reset        = 1'b1;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    tick();
    tick();
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_prod", 32'(product), 32'd0);
    reset = 1'b0;
    tick();

    // Case 1: 13*11 with explicit edge-by-edge timing.
    multiplicand = 8'd13;
    multiplier   = 8'd11;
    start        = 1'b1;
    tick();
    start = 1'b0;
    check_eq("c1_busy_e0", 32'(busy), 32'd1);
    for (int k = 1; k <= 7; k++) tick();
    check_eq("c1_done_e7", 32'(done), 32'd0);
    tick();
    check_eq("c1_done_e8", 32'(done), 32'd1);
    check_eq("c1_prod", 32'(product), 32'h008F);
    tick();
    check_eq("c1_idle_e9", {30'd0, busy, done}, 32'd0);

    // Case 2: full carry propagation into bit 15.
    run_op("c2", 8'd255, 8'd255, 16'hFE01, 8);
    run_op("c2b", 8'd1, 8'd255, 16'h00FF, 8);

    // Case 3: zero operands.
    run_op("c3", 8'd0, 8'd200, 16'h0000, ZERO_LAT);
    run_op("c3b", 8'd77, 8'd0, 16'h0000, ZERO_LAT);

    // Case 4: start during RUN ignored and not queued.
    multiplicand = 8'd7;
    multiplier   = 8'd9;
    start        = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    multiplicand = 8'd100;
    multiplier   = 8'd100;
    start        = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n);
    check_eq("c4_lat", 32'(n + 3), 32'd8);
    check_eq("c4_prod", 32'(product), 32'd63);
    tick();
    tick();
    tick();
    check_eq("c4_noqueue", {30'd0, busy, done}, 32'd0);

    // Case 5: asynchronous reset mid-RUN.
    multiplicand = 8'd200;
    multiplier   = 8'd3;
    start        = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 4; k++) tick();
    check_eq("c5_busy_pre", 32'(busy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("c5_async", {13'd0, busy, done, product}, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done || busy) seen++;
    end
    check_eq("c5_nodone", 32'(seen), 32'd0);
    run_op("c5_new", 8'd5, 8'd6, 16'd30, 8);

    // Case 6: start held high for three back-to-back operations.
    multiplicand = 8'd2;
    multiplier   = 8'd3;
    start        = 1'b1;
    tick();
    multiplicand = 8'd4;
    multiplier   = 8'd5;
    wait_done(n);
    check_eq("c6_lat1", 32'(n), 32'd8);
    check_eq("c6_prod1", 32'(product), 32'd6);
    d1 = cyc;
    tick();
    tick();
    multiplicand = 8'd15;
    multiplier   = 8'd17;
    wait_done(n);
    check_eq("c6_prod2", 32'(product), 32'd20);
    d2 = cyc;
    check_eq("c6_gap1", 32'(d2 - d1), 32'd10);
    tick();
    tick();
    start = 1'b0;
    wait_done(n);
    check_eq("c6_prod3", 32'(product), 32'd255);
    check_eq("c6_gap2", 32'(cyc - d2), 32'd10);
    tick();
    check_eq("c6_idle", {30'd0, busy, done}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
